// File: rtl/msrv32_dmem_responder.sv
// Data-memory responder for msrv32: NONSEQ transfers, fixed wait states, byte-masked writes, registered reads.
// Optional feature: define MSRV32_DMEM_RANGE_CHECK_EN to flag out-of-range addresses with dmerr_out.
module msrv32_dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic        ms_riscv32_mp_dmrd_req_in,
  input  logic [1:0]  ahb_htrans_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ms_riscv32_mp_ahb_ready_out,
  output logic        ms_riscv32_mp_dmerr_out
);

  localparam int         DEPTH         = 1 << ADDR_WIDTH;
  localparam logic [3:0] WCNT_INIT     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic [3:0] wcnt;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic [ADDR_WIDTH-1:0] in_idx;
  logic                  in_oor;

  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [31:0]           lat_data;
  logic [3:0]            lat_mask;
  logic                  lat_wr;
  logic                  lat_oor;

  logic                  cmp_fire;
  logic [ADDR_WIDTH-1:0] cmp_idx;
  logic [31:0]           cmp_data;
  logic [3:0]            cmp_mask;
  logic                  cmp_wr;
  logic                  cmp_oor;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ms_riscv32_mp_dmaddr_in[1:0], ms_riscv32_mp_dmaddr_in[31:ADDR_WIDTH+2]};

  assign in_idx = ms_riscv32_mp_dmaddr_in[ADDR_WIDTH+1:2];

`ifdef MSRV32_DMEM_RANGE_CHECK_EN
  assign in_oor = |ms_riscv32_mp_dmaddr_in[31:ADDR_WIDTH+2];
`else
  assign in_oor = 1'b0;
`endif

  // Gated by reset so a zero-wait-state build cannot write RAM while reset is held.
  assign accept = ms_riscv32_mp_rst_n_in && (state == S_IDLE) &&
                  (ahb_htrans_in == HTRANS_NONSEQ) &&
                  (ms_riscv32_mp_dmwr_req_in || ms_riscv32_mp_dmrd_req_in);

  // Zero wait states complete straight from the bus; otherwise from the latched transfer.
  assign cmp_fire = (WAIT_STATES == 0) ? accept : ((state == S_WAIT) && (wcnt == 4'd0));
  assign cmp_idx  = (WAIT_STATES == 0) ? in_idx : lat_idx;
  assign cmp_data = (WAIT_STATES == 0) ? ms_riscv32_mp_dmdata_in : lat_data;
  assign cmp_mask = (WAIT_STATES == 0) ? ms_riscv32_mp_dmwr_mask_in : lat_mask;
  assign cmp_wr   = (WAIT_STATES == 0) ? ms_riscv32_mp_dmwr_req_in : lat_wr;
  assign cmp_oor  = (WAIT_STATES == 0) ? in_oor : lat_oor;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && (WAIT_STATES != 0)) state_next = S_WAIT;
      S_WAIT: if (wcnt == 4'd0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      wcnt     <= 4'd0;
      lat_idx  <= '0;
      lat_data <= 32'h0;
      lat_mask <= 4'h0;
      lat_wr   <= 1'b0;
      lat_oor  <= 1'b0;
    end else if (accept) begin
      wcnt     <= WCNT_INIT;
      lat_idx  <= in_idx;
      lat_data <= ms_riscv32_mp_dmdata_in;
      lat_mask <= ms_riscv32_mp_dmwr_mask_in;
      lat_wr   <= ms_riscv32_mp_dmwr_req_in;
      lat_oor  <= in_oor;
    end else if ((state == S_WAIT) && (wcnt != 4'd0)) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (cmp_fire && cmp_wr && !cmp_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (cmp_mask[b]) mem[cmp_idx][8*b +: 8] <= cmp_data[8*b +: 8];
      end
    end
  end

  // Read data holds until the next read completes; writes leave it alone.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      ms_riscv32_mp_dmdata_out <= 32'h0;
    end else if (cmp_fire && !cmp_wr) begin
      ms_riscv32_mp_dmdata_out <= cmp_oor ? 32'h0 : mem[cmp_idx];
    end
  end

`ifdef MSRV32_DMEM_RANGE_CHECK_EN
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      ms_riscv32_mp_dmerr_out <= 1'b0;
    end else begin
      ms_riscv32_mp_dmerr_out <= cmp_fire && cmp_oor;
    end
  end
`else
  logic unused_oor;
  assign unused_oor = cmp_oor;
  assign ms_riscv32_mp_dmerr_out = 1'b0;
`endif

  assign ms_riscv32_mp_ahb_ready_out = (state == S_IDLE);

endmodule
